// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic                  CLEAR_N,
   input  logic [NREQ-1:0]       REQ_VALID,
   input  logic [NREQ*WIDTH-1:0] REQ_DATA,
   output logic [NREQ-1:0]       REQ_READY,
   input  logic                  FIFO_FULL_N,
   output logic                  FIFO_WRITE,
   output logic [WIDTH-1:0]      FIFO_DATA,
   output logic [OW-1:0]         OWNER,
   output logic                  BUSY
);
   typedef enum logic {IDLE, BURST} st_t;
   st_t st;
   logic [OW-1:0] ptr, own, win, sel, idx;
   logic [CW-1:0] cnt;
   logic gap, any, go;

   function automatic logic [OW-1:0] inc(input logic [OW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = OW'((int'(ptr) + k) % NREQ);
         if (!any && REQ_VALID[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end

   // gap forces the single re-arbitration bubble after a burst that ran to full length
   assign sel        = (st == BURST) ? own : win;
   assign go         = RESET_N && CLEAR_N && FIFO_FULL_N && ((st == BURST) ? REQ_VALID[own] : (any && !gap));
   assign REQ_READY  = go ? (NREQ'(1) << sel) : '0;
   assign FIFO_WRITE = |(REQ_VALID & REQ_READY);
   assign FIFO_DATA  = FIFO_WRITE ? REQ_DATA[sel*WIDTH +: WIDTH] : '0;
   assign BUSY       = (st == BURST);
   assign OWNER      = BUSY ? own : '0;

   always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
         st  <= IDLE;
         ptr <= '0;
         own <= '0;
         cnt <= '0;
         gap <= 1'b0;
      end else if (!CLEAR_N) begin
         st  <= IDLE;
         ptr <= '0;
         own <= '0;
         cnt <= '0;
         gap <= 1'b0;
      end else if (st == IDLE) begin
         gap <= 1'b0;
         if (go) begin
            own <= win;
            if (MAX_BURST == 1) begin
               ptr <= inc(win);
               gap <= 1'b1;
            end else begin
               st  <= BURST;
               cnt <= CW'(1);
            end
         end
      end else if (!REQ_VALID[own]) begin
         st  <= IDLE;
         ptr <= inc(own);
         cnt <= '0;
      end else if (FIFO_FULL_N) begin
         if (cnt == CW'(MAX_BURST - 1)) begin
            st  <= IDLE;
            ptr <= inc(own);
            cnt <= '0;
            gap <= 1'b1;
         end else
            cnt <= cnt + 1'b1;
      end

   assert property (@(posedge CLOCK) disable iff (!RESET_N) $onehot0(REQ_READY));
   assert property (@(posedge CLOCK) disable iff (!RESET_N) !(FIFO_WRITE && !FIFO_FULL_N));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario tasks plus randomized traffic against a queue-based reference
module tb_fifo_wr_arbiter;
   localparam int W = 8, N = 4, MB = 4, DEPTH = 32;
   logic CLOCK = 0, RESET_N = 0, CLEAR_N = 1, FIFO_FULL_N = 1;
   logic FIFO_WRITE, BUSY;
   logic [N-1:0] REQ_VALID = '0, REQ_READY;
   logic [N*W-1:0] REQ_DATA = '0;
   logic [W-1:0] FIFO_DATA;
   logic [1:0] OWNER;
   int checks = 0, errors = 0;
   logic [W-1:0] pq[N][$];
   logic [W-1:0] fq[$];
   logic [N-1:0] wr_ready[$];
   bit vhold[N];
   int rate, rd_rate, full_hold, clr_rate;
   bit refill;
   string trace;
   int m_owner, m_words, m_prio, e_win;
   bit m_gap;
   logic [N-1:0] e_ready;
   logic e_write, e_busy;
   logic [W-1:0] e_data;
   logic [1:0] e_owner;

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .REQ_VALID(REQ_VALID),
      .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .FIFO_FULL_N(FIFO_FULL_N),
      .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA), .OWNER(OWNER), .BUSY(BUSY));

   always #5 CLOCK = ~CLOCK;

   // the burst owner keeps the port until its word count hits MB, it drops VALID, or reset/clear
   task automatic model_outputs();
      int w = -1;
      e_busy  = m_owner >= 0;
      e_owner = e_busy ? 2'(m_owner) : 2'd0;
      if (RESET_N && CLEAR_N && FIFO_FULL_N) begin
         if (m_owner >= 0) w = REQ_VALID[m_owner] ? m_owner : -1;
         else if (!m_gap)
            for (int j = 0; j < N; j++)
               if (w < 0 && REQ_VALID[(m_prio + j) % N]) w = (m_prio + j) % N;
      end
      e_win   = w;
      e_write = w >= 0;
      e_ready = '0;
      if (w >= 0) e_ready[w] = 1'b1;
      e_data  = (w >= 0) ? pq[w][0] : '0;
   endtask

   task automatic drive();
      CLEAR_N = !(clr_rate > 0 && $urandom_range(99) < clr_rate);
      for (int i = 0; i < N; i++) begin
         REQ_VALID[i] = pq[i].size() > 0 && (vhold[i] || $urandom_range(99) < rate);
         REQ_DATA[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : '0;
      end
      FIFO_FULL_N = fq.size() < DEPTH && full_hold == 0;
      model_outputs();
   endtask

   task automatic advance();
      trace = {trace, FIFO_WRITE ? "1" : "0"};
      if (FIFO_WRITE) wr_ready.push_back(REQ_READY);
      @(posedge CLOCK);
      if (e_write) fq.push_back(pq[e_win].pop_front());
      for (int i = 0; i < N; i++) vhold[i] = REQ_VALID[i] && !e_ready[i];
      if (!RESET_N || !CLEAR_N) begin
         m_owner = -1; m_prio = 0; m_gap = 0; m_words = 0;
      end else if (m_owner >= 0) begin
         if (!REQ_VALID[m_owner]) begin
            m_prio = (m_owner + 1) % N; m_owner = -1;
         end else if (e_write) begin
            m_words++;
            if (m_words == MB) begin
               m_prio = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
            end
         end
      end else begin
         m_gap = 0;
         if (e_win >= 0) begin
            m_words = 1;
            if (MB == 1) begin
               m_prio = (e_win + 1) % N; m_gap = 1;
            end else m_owner = e_win;
         end
      end
      if (fq.size() > 0 && $urandom_range(99) < rd_rate) void'(fq.pop_front());
      if (full_hold > 0) full_hold--;
      if (refill && $urandom_range(2) == 0) begin
         int i = $urandom_range(N - 1);
         if (pq[i].size() < 4) pq[i].push_back(W'($urandom));
      end
      @(negedge CLOCK);
   endtask

   task automatic reset_dut();
      RESET_N = 0; CLEAR_N = 1; rate = 100; rd_rate = 0; full_hold = 0; clr_rate = 0; refill = 0;
      for (int i = 0; i < N; i++) begin
         pq[i].delete(); vhold[i] = 0;
      end
      fq.delete(); wr_ready.delete(); trace = "";
      m_owner = -1; m_prio = 0; m_gap = 0; m_words = 0;
      REQ_VALID = '0; REQ_DATA = '0; FIFO_FULL_N = 1;
      @(negedge CLOCK); @(negedge CLOCK);
      RESET_N = 1;
   endtask

   task automatic test_reset();
      reset_dut();
      RESET_N = 0;
      for (int i = 0; i < N; i++) pq[i].push_back(W'(8'h70 + i));
      drive(); #1;
      checks++;
      if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY});
      end
      advance();
      RESET_N = 1;
      drive(); #1;
      checks++;
      if (REQ_READY !== 4'b0001 || FIFO_DATA !== 8'h70) begin
         errors++; $display("FAIL reset_first_grant got %b/%h want 0001/70", REQ_READY, FIFO_DATA);
      end
      advance();
   endtask

   task automatic test_single_producer();
      reset_dut();
      for (int k = 0; k < 10; k++) pq[1].push_back(W'(8'h10 + k));
      repeat (14) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL single_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         advance();
      end
      checks++;
      if (trace != "11110111101100") begin
         errors++; $display("FAIL single_pattern got %s want 11110111101100", trace);
      end
      checks++;
      if (fq.size() != 10) begin
         errors++; $display("FAIL single_count got %0d want 10", fq.size());
      end else
         for (int k = 0; k < 10; k++)
            if (fq[k] !== W'(8'h10 + k)) begin
               errors++; $display("FAIL single_order idx %0d got %h want %h", k, fq[k], 8'h10 + k);
            end
   endtask

   task automatic test_round_robin();
      reset_dut();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < ((i == 0) ? 8 : 4); k++) pq[i].push_back(W'(i * 16 + k));
      repeat (24) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL rr_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         advance();
      end
      checks++;
      if (trace != "111101111011110111101111") begin
         errors++; $display("FAIL rr_pattern got %s want 111101111011110111101111", trace);
      end
      checks++;
      if (wr_ready.size() != 20) begin
         errors++; $display("FAIL rr_writes got %0d want 20", wr_ready.size());
      end else
         for (int w = 0; w < 20; w++)
            if (wr_ready[w] !== 4'(1 << ((w / 4) % 4))) begin
               errors++; $display("FAIL rr_owner write %0d got %b want %b", w, wr_ready[w], 4'(1 << ((w / 4) % 4)));
            end
   endtask

   task automatic test_full_stall();
      reset_dut();
      for (int k = 0; k < 4; k++) pq[2].push_back(W'(8'hA0 + k));
      for (int c = 0; c < 10; c++) begin
         if (c == 2) full_hold = 5;
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL full_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         if (c >= 2 && c < 7) begin
            checks++;
            if (FIFO_WRITE !== 1'b0 || OWNER !== 2'd2 || BUSY !== 1'b1) begin
               errors++; $display("FAIL full_hold got w%b o%0d b%b want w0 o2 b1", FIFO_WRITE, OWNER, BUSY);
            end
         end
         advance();
      end
      checks++;
      if (trace != "1100000110") begin
         errors++; $display("FAIL full_pattern got %s want 1100000110", trace);
      end
   endtask

   task automatic test_release_wrap();
      reset_dut();
      pq[2].push_back(8'hC2);
      repeat (3) begin
         drive(); #1; advance();
      end
      trace = "";
      pq[3].push_back(8'hD3);
      pq[0].push_back(8'hE0);
      pq[0].push_back(8'hE1);
      for (int c = 0; c < 5; c++) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL release_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         if (c == 0 || c == 2) begin
            checks++;
            if (REQ_READY !== ((c == 0) ? 4'b1000 : 4'b0001)) begin
               errors++; $display("FAIL release_winner cyc %0d got %b want %b", c, REQ_READY, (c == 0) ? 4'b1000 : 4'b0001);
            end
         end
         advance();
      end
      checks++;
      if (trace != "10110") begin
         errors++; $display("FAIL release_pattern got %s want 10110", trace);
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      for (int k = 0; k < 4; k++) pq[1].push_back(W'(8'h30 + k));
      repeat (2) begin
         drive(); #1; advance();
      end
      drive(); #1;
      checks++;
      if (BUSY !== 1'b1 || OWNER !== 2'd1 || FIFO_WRITE !== 1'b1) begin
         errors++; $display("FAIL areset_pre got b%b o%0d w%b want b1 o1 w1", BUSY, OWNER, FIFO_WRITE);
      end
      #1 RESET_N = 0;
      #1 checks++;
      if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== '0) begin
         errors++; $display("FAIL areset_outputs got %h want 0", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY});
      end
      m_owner = -1; m_prio = 0; m_gap = 0; m_words = 0;
      model_outputs();
      advance();
      for (int k = 0; k < 4; k++) pq[0].push_back(W'(8'h40 + k));
      RESET_N = 1;
      for (int c = 0; c < 6; c++) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL areset_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         if (c == 0) begin
            checks++;
            if (REQ_READY !== 4'b0001) begin
               errors++; $display("FAIL areset_winner got %b want 0001", REQ_READY);
            end
         end
         advance();
      end
   endtask

   task automatic test_fill();
      int ones = 0;
      int next_k[N];
      reset_dut();
      for (int i = 0; i < N; i++) begin
         next_k[i] = 0;
         for (int k = 0; k < 12; k++) pq[i].push_back(W'(i * 16 + k));
      end
      repeat (50) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL fill_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         advance();
      end
      for (int c = 0; c < trace.len(); c++) if (trace[c] == "1") ones++;
      checks++;
      if (ones != DEPTH || fq.size() != DEPTH) begin
         errors++; $display("FAIL fill_count got %0d/%0d want %0d", ones, fq.size(), DEPTH);
      end
      checks++;
      foreach (fq[j]) begin
         if (int'(fq[j][3:0]) != next_k[fq[j][5:4]]) begin
            errors++; $display("FAIL fill_order idx %0d got %h", j, fq[j]);
            break;
         end
         next_k[fq[j][5:4]]++;
      end
   endtask

   task automatic test_random();
      reset_dut();
      rate = 50; rd_rate = 45; clr_rate = 2; refill = 1;
      repeat (600) begin
         drive(); #1; checks++;
         if ({REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY} !== {e_ready, e_write, e_data, e_owner, e_busy}) begin
            errors++; $display("FAIL random_cycle got %h want %h", {REQ_READY, FIFO_WRITE, FIFO_DATA, OWNER, BUSY}, {e_ready, e_write, e_data, e_owner, e_busy});
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_single_producer();
      test_round_robin();
      test_full_stall();
      test_release_wrap();
      test_async_reset();
      test_fill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
